ppm_frame_scheduler: RTL and testbench

//  Frame-level controller for the PPM transmit path. Buffers bytes arriving from the byte deserialiser in a 16-deep FIFO
//  and decides when to send a frame. Sequences each frame as SOF slot, 4 DATA symbol slots per byte, EOF slot, then gap.

---
 rtl/ppm_pkg.sv | 37 +++
 rtl/ppm_byte_fifo.sv | 57 +++++
 rtl/ppm_frame_scheduler.sv | 174 +++++++++++++++++
 tb/tb_ppm_frame_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// Shared definitions for the PPM transmit path: encoder order codes,
// frame-scheduler state encoding, default timing parameters, and a
// state-to-order mapping function.
package ppm_pkg;

  typedef enum logic [1:0] {
    ORD_IDLE = 2'b00,
    ORD_SOF  = 2'b01,
    ORD_DATA = 2'b10,
    ORD_EOF  = 2'b11
  } order_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF,
    ST_GAP
  } sched_state_e;

  localparam int unsigned SLOT_CYCLES_DEF  = 128;
  localparam int unsigned EOF_CYCLES_DEF   = 64;
  localparam int unsigned GAP_CYCLES_DEF   = 32;
  localparam int unsigned FIFO_DEPTH_DEF   = 16;
  localparam int unsigned IDLE_TIMEOUT_DEF = 1024;

  // GAP shares the IDLE order code; the encoder sees no difference.
  function automatic order_e state_order(input sched_state_e s);
    case (s)
      ST_SOF:  return ORD_SOF;
      ST_DATA: return ORD_DATA;
      ST_EOF:  return ORD_EOF;
      default: return ORD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ppm_byte_fifo.sv
// Synchronous byte FIFO with a show-ahead head output.
// Ports:
//   clk, rst       clock, synchronous active-low reset (empties the FIFO)
//   push_i, din_i  write request and data (ignored when full)
//   pop_i          read request (ignored when empty); head_o advances next edge
//   head_o         current oldest entry, valid whenever empty_o is low
//   count_o        number of entries held, 0..DEPTH
//   full_o         count_o == DEPTH
//   empty_o        count_o == 0
module ppm_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/ppm_frame_scheduler.sv
// Frame-level controller for the PPM transmit path. Buffers incoming bytes
// and sequences frames as SOF slot, 4 DATA symbols per byte, EOF slot, GAP.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   byte_in/byte_valid  byte from deserialiser; accepted when byte_ready
//   byte_ready          FIFO not full
//   flush               1-cycle request to send pending bytes now
//   order               00 IDLE, 01 SOF, 10 DATA, 11 EOF
//   slot_cnt            clock index within current slot
//   sym_idx             2-bit symbol index within cur_byte
//   cur_byte            byte being encoded
//   fifo_count          bytes held, 0..16
//   busy                high from SOF start through last GAP cycle
//   frame_done          pulse on last EOF cycle
module ppm_frame_scheduler
  import ppm_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = SLOT_CYCLES_DEF,
  parameter int unsigned EOF_CYCLES   = EOF_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       flush,
  output logic [1:0] order,
  output logic [9:0] slot_cnt,
  output logic [1:0] sym_idx,
  output logic [7:0] cur_byte,
  output logic [4:0] fifo_count,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF;
  localparam int unsigned TW         = $clog2(IDLE_TIMEOUT);
  localparam logic [9:0]    SLOT_LAST = 10'(SLOT_CYCLES - 1);
  localparam logic [9:0]    EOF_LAST  = 10'(EOF_CYCLES - 1);
  localparam logic [9:0]    GAP_LAST  = 10'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(IDLE_TIMEOUT - 1);

  sched_state_e  state_q, state_d;
  logic [9:0]    slot_q, slot_d;
  logic [1:0]    sym_q, sym_d;
  logic [7:0]    cur_q, cur_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    sent_q, sent_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic       push, pop, trigger;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;

  ppm_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (byte_in),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign byte_ready = !fifo_full;
  assign push       = byte_valid && !fifo_full;
  assign order      = state_order(state_q);
  assign slot_cnt   = slot_q;
  assign sym_idx    = sym_q;
  assign cur_byte   = cur_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_EOF) && (slot_q == EOF_LAST);

  assign trigger = (state_q == ST_IDLE) && !fifo_empty &&
                   ((fifo_count == 5'(FIFO_DEPTH)) || flush || (tmr_q == TMR_LAST));

  always_comb begin
    if (push || trigger || state_q != ST_IDLE) tmr_d = '0;
    else if (!fifo_empty && tmr_q != TMR_LAST) tmr_d = tmr_q + 1'b1;
    else                                        tmr_d = tmr_q;
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sym_d   = sym_q;
    cur_d   = cur_q;
    len_d   = len_q;
    sent_d  = sent_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        slot_d = '0;
        if (trigger) begin
          state_d = ST_SOF;
          len_d   = fifo_count;
          sent_d  = '0;
        end
      end
      ST_SOF: begin
        if (slot_q == SLOT_LAST) begin
          state_d = ST_DATA;
          slot_d  = '0;
          sym_d   = '0;
          pop     = 1'b1;
          cur_d   = fifo_head;
          sent_d  = 5'd1;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (sym_q != 2'd3) begin
            sym_d = sym_q + 1'b1;
          end else if (sent_q < len_q) begin
            sym_d  = '0;
            pop    = 1'b1;
            cur_d  = fifo_head;
            sent_d = sent_q + 1'b1;
          end else begin
            state_d = ST_EOF;
            sym_d   = '0;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      ST_EOF: begin
        if (slot_q == EOF_LAST) begin
          state_d = ST_GAP;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (slot_q == GAP_LAST) begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      sym_q   <= '0;
      cur_q   <= '0;
      len_q   <= '0;
      sent_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sym_q   <= sym_d;
      cur_q   <= cur_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: tb/tb_ppm_frame_scheduler.sv
// Self-checking bench for ppm_frame_scheduler. Inputs are driven and outputs
// sampled on the falling clock edge. Expected frame waveforms are computed
// from the time offset within the frame with plain arithmetic; a byte queue
// models the FIFO contents.
module tb_ppm_frame_scheduler;

  localparam int SLOT = 128;
  localparam int EOFC = 64;
  localparam int GAPC = 32;
  localparam int TOUT = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       flush;
  logic [1:0] order;
  logic [9:0] slot_cnt;
  logic [1:0] sym_idx;
  logic [7:0] cur_byte;
  logic [4:0] fifo_count;
  logic       busy;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;
  logic [7:0] mq[$];

  ppm_frame_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .flush      (flush),
    .order      (order),
    .slot_cnt   (slot_cnt),
    .sym_idx    (sym_idx),
    .cur_byte   (cur_byte),
    .fifo_count (fifo_count),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Follows one whole frame (SOF..GAP) starting at its first SOF cycle and
  // optionally pushes `extra` bytes starting at frame cycle `push_at`.
  task automatic follow_frame(input int n, input int extra, input int push_at, input string tag);
    logic [7:0] fb[$];
    int total, data_end, eof_end, base, done_at;
    logic [29:0] exp_v, obs_v;
    total    = SLOT * (1 + 4 * n) + EOFC + GAPC;
    data_end = SLOT * (1 + 4 * n);
    eof_end  = data_end + EOFC;
    for (int k = 0; k < n; k++) fb.push_back(mq.pop_front());
    base    = n + mq.size();
    done_at = -1;
    for (int t = 0; t < total; t++) begin
      int eo, es, esym, ebusy, edone, popped, pushed, ecnt;
      logic [7:0] ecur;
      eo = 0; es = 0; esym = 0; ecur = 8'h00; ebusy = 1; edone = 0;
      if (t < SLOT) begin
        eo = 1; es = t; popped = 0;
      end else if (t < data_end) begin
        eo = 2; es = (t - SLOT) % SLOT; esym = ((t - SLOT) / SLOT) % 4;
        ecur = fb[(t - SLOT) / (4 * SLOT)]; popped = (t - SLOT) / (4 * SLOT) + 1;
      end else if (t < eof_end) begin
        eo = 3; es = t - data_end; edone = (es == EOFC - 1) ? 1 : 0; popped = n;
      end else begin
        eo = 0; popped = n;
      end
      pushed = (t <= push_at) ? 0 : ((t - push_at > extra) ? extra : t - push_at);
      ecnt   = base + pushed - popped;
      exp_v = {2'(eo), 10'(es), 2'(esym), ecur, 1'(ebusy), 1'(edone), 5'(ecnt), 1'(ecnt != 16)};
      obs_v = {order, (eo == 0) ? 10'd0 : slot_cnt, (eo == 2) ? sym_idx : 2'd0,
               (eo == 2) ? cur_byte : 8'h00, busy, frame_done, fifo_count, byte_ready};
      if (frame_done === 1'b1 && done_at < 0) done_at = t;
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL %s_cycle t=%0d got=%h exp=%h", tag, t, obs_v, exp_v);
      end
      if (t >= push_at && t < push_at + extra) begin
        byte_valid = 1'b1;
        byte_in    = 8'($urandom);
        mq.push_back(byte_in);
      end else begin
        byte_valid = 1'b0;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    checks++;
    if (done_at !== eof_end - 1) begin
      failures++;
      $display("FAIL %s_done_time got=%0d exp=%0d", tag, done_at, eof_end - 1);
    end
    checks++;
    if (order !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_back_idle order=%b busy=%b exp order=00 busy=0", tag, order, busy);
    end
  endtask

  task automatic push_bytes(input int n, input logic rnd);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_in    = rnd ? 8'($urandom) : 8'h00;
      mq.push_back(byte_in);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({order, slot_cnt, sym_idx, cur_byte, fifo_count, busy, frame_done, byte_ready} !== 30'h1) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b",
               {order, slot_cnt, sym_idx, cur_byte, fifo_count, busy, frame_done, byte_ready}, 30'h1);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (order !== 2'b00 || busy !== 1'b0 || fifo_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_release order=%b busy=%b count=%0d exp 00/0/0", order, busy, fifo_count);
    end
    mq.delete();
  endtask

  task automatic test_flush_frame();
    byte_valid = 1'b1; byte_in = 8'hA5; mq.push_back(8'hA5); @(negedge clk);
    byte_in = 8'h3C; mq.push_back(8'h3C); @(negedge clk);
    byte_in = 8'hFF; mq.push_back(8'hFF); @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (fifo_count !== 5'd3 || order !== 2'b00) begin
      failures++;
      $display("FAIL flush_pre count=%0d order=%b exp 3/00", fifo_count, order);
    end
    pulse_flush();
    checks++;
    if (order !== 2'b01) begin
      failures++;
      $display("FAIL flush_start order=%b exp=01", order);
    end
    follow_frame(3, 0, 0, "flush3");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (byte_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready i=%0d got=%b exp=1", i, byte_ready);
      end
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      mq.push_back(byte_in);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    checks++;
    if (fifo_count !== 5'd16 || byte_ready !== 1'b0 || order !== 2'b00) begin
      failures++;
      $display("FAIL b2b_full count=%0d ready=%b order=%b exp 16/0/00", fifo_count, byte_ready, order);
    end
    @(negedge clk);
    checks++;
    if (order !== 2'b01) begin
      failures++;
      $display("FAIL b2b_autostart order=%b exp=01", order);
    end
    follow_frame(16, 0, 0, "full16");
  endtask

  task automatic test_idle_timeout();
    int cnt;
    push_bytes(1, 1'b1);
    cnt = 0;
    while (order !== 2'b01 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== TOUT) begin
      failures++;
      $display("FAIL timeout_delay got=%0d exp=%0d", cnt, TOUT);
    end
    if (order === 2'b01) follow_frame(1, 0, 0, "timeout1");
  endtask

  task automatic test_push_during_frame();
    int pa, stray;
    push_bytes(2, 1'b1);
    pulse_flush();
    checks++;
    if (order !== 2'b01) begin
      failures++;
      $display("FAIL midpush_start order=%b exp=01", order);
    end
    pa = $urandom_range(200, 1100);
    follow_frame(2, 5, pa, "midpush2");
    checks++;
    if (fifo_count !== 5'd5) begin
      failures++;
      $display("FAIL midpush_left count=%0d exp=5", fifo_count);
    end
    stray = 0;
    repeat (100) begin
      if (order !== 2'b00 || busy !== 1'b0) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL midpush_no_autostart active_cycles=%0d exp=0", stray);
    end
    pulse_flush();
    checks++;
    if (order !== 2'b01) begin
      failures++;
      $display("FAIL second_start order=%b exp=01", order);
    end
    follow_frame(5, 0, 0, "second5");
  endtask

  task automatic test_reset_mid_frame();
    int stray;
    push_bytes(4, 1'b1);
    pulse_flush();
    repeat (SLOT + 2 * SLOT + 50) @(negedge clk);
    checks++;
    if (order !== 2'b10 || sym_idx !== 2'd2 || slot_cnt !== 10'd50) begin
      failures++;
      $display("FAIL abort_point order=%b sym=%0d slot=%0d exp 10/2/50", order, sym_idx, slot_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    checks++;
    if ({order, slot_cnt, sym_idx, cur_byte, fifo_count, busy, frame_done, byte_ready} !== 30'h1) begin
      failures++;
      $display("FAIL abort_values got=%b exp=%b",
               {order, slot_cnt, sym_idx, cur_byte, fifo_count, busy, frame_done, byte_ready}, 30'h1);
    end
    stray = 0;
    repeat (200) begin
      if (order !== 2'b00 || busy !== 1'b0 || frame_done !== 1'b0) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL abort_quiet active_cycles=%0d exp=0", stray);
    end
  endtask

  task automatic test_empty_flush();
    int stray;
    stray = 0;
    pulse_flush();
    repeat (50) begin
      if (order !== 2'b00 || busy !== 1'b0) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0 || fifo_count !== 5'd0) begin
      failures++;
      $display("FAIL empty_flush active_cycles=%0d count=%0d exp 0/0", stray, fifo_count);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_flush_frame();
    test_back_to_back();
    test_idle_timeout();
    test_push_during_frame();
    test_reset_mid_frame();
    test_empty_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
